// File: rtl/clock_rate_detector.sv
// Measures the period of a slow square-wave input in CLOCK_50 cycles, classifies its rate and
// flags lock / loss-of-signal. Define CLOCK_RATE_DETECTOR_DUTY_EN to also measure the high time.
module clock_rate_detector #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned TOL_CYC     = 500000,
    parameter int unsigned TIMEOUT_CYC = 250000000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        clk_in,
    input  logic        clear,
    output logic [27:0] period_cyc,
    output logic [27:0] high_cyc,
    output logic        period_valid,
    output logic [2:0]  rate_code,
    output logic        locked,
    output logic        timeout
);

    localparam logic [27:0]        TMO  = 28'(TIMEOUT_CYC);
    localparam logic signed [28:0] TOL  = 29'(TOL_CYC);
    localparam logic signed [28:0] P2   = 29'(CLK_HZ / 2);
    localparam logic signed [28:0] P1   = 29'(CLK_HZ);
    localparam logic signed [28:0] P05  = 29'(2 * CLK_HZ);
    localparam logic signed [28:0] P025 = 29'(4 * CLK_HZ);

    typedef enum logic [1:0] {StIdle, StMeasure, StLos} state_e;

    state_e      state_q, state_d;
    logic [2:0]  sync_q, sync_d;
    logic        edg, fedg;
    logic [27:0] cnt_q, cnt_d;
    logic [27:0] period_q, period_d;
    logic [2:0]  code_q, code_d;
    logic        pv_q, pv_d;
    logic        locked_q, locked_d;
    logic        tmo_q, tmo_d;
    logic [2:0]  new_code;

    function automatic logic near(input logic [27:0] c, input logic signed [28:0] p);
        logic signed [28:0] d;
        d = $signed({1'b0, c}) - p;
        if (d < 0) d = -d;
        return d <= TOL;
    endfunction

    // sync_q[1] is the synchronized input, sync_q[2] its delayed copy for edge detect
    assign edg  = sync_q[1] & ~sync_q[2];
    assign fedg = ~sync_q[1] & sync_q[2];

    always_comb begin
        new_code = 3'd0;
        if (near(cnt_q, P025))     new_code = 3'd1;
        else if (near(cnt_q, P05)) new_code = 3'd2;
        else if (near(cnt_q, P1))  new_code = 3'd3;
        else if (near(cnt_q, P2))  new_code = 3'd4;
    end

    always_comb begin
        sync_d   = {sync_q[1:0], clk_in};
        state_d  = state_q;
        period_d = period_q;
        code_d   = code_q;
        pv_d     = 1'b0;
        locked_d = locked_q;
        tmo_d    = tmo_q;

        if (edg)               cnt_d = 28'd1;
        else if (cnt_q == TMO) cnt_d = cnt_q;
        else                   cnt_d = cnt_q + 28'd1;

        case (state_q)
            StIdle, StMeasure: begin
                if (edg) begin
                    state_d = StMeasure;
                    if (state_q == StMeasure) begin
                        period_d = cnt_q;
                        pv_d     = 1'b1;
                        code_d   = new_code;
                        locked_d = (new_code == code_q) && (new_code != 3'd0);
                    end
                end else if (cnt_q == TMO) begin
                    state_d  = StLos;
                    tmo_d    = 1'b1;
                    code_d   = 3'd7;
                    locked_d = 1'b0;
                end
            end
            StLos: begin
                if (edg) begin
                    state_d = StMeasure;
                    tmo_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (clear) begin
            sync_d   = 3'd0;
            state_d  = StIdle;
            cnt_d    = 28'd0;
            period_d = 28'd0;
            code_d   = 3'd0;
            pv_d     = 1'b0;
            locked_d = 1'b0;
            tmo_d    = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync_q   <= 3'd0;
            state_q  <= StIdle;
            cnt_q    <= 28'd0;
            period_q <= 28'd0;
            code_q   <= 3'd0;
            pv_q     <= 1'b0;
            locked_q <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            code_q   <= code_d;
            pv_q     <= pv_d;
            locked_q <= locked_d;
            tmo_q    <= tmo_d;
        end
    end

    assign period_cyc   = period_q;
    assign period_valid = pv_q;
    assign rate_code    = code_q;
    assign locked       = locked_q;
    assign timeout      = tmo_q;

`ifdef CLOCK_RATE_DETECTOR_DUTY_EN
    logic [27:0] hcnt_q, hcnt_d;
    logic [27:0] high_q, high_d;
    logic        hrun_q, hrun_d;

    always_comb begin
        hcnt_d = hcnt_q;
        hrun_d = hrun_q;
        high_d = high_q;
        if (edg) begin
            hcnt_d = 28'd1;
            hrun_d = 1'b1;
        end else if (fedg) begin
            hrun_d = 1'b0;
        end else if (hrun_q && hcnt_q != TMO) begin
            hcnt_d = hcnt_q + 28'd1;
        end
        // Still running at the closing edge means no fall was seen: high time is the period
        if (pv_d) high_d = hrun_q ? cnt_q : hcnt_q;
        if (clear) begin
            hcnt_d = 28'd0;
            hrun_d = 1'b0;
            high_d = 28'd0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            hcnt_q <= 28'd0;
            hrun_q <= 1'b0;
            high_q <= 28'd0;
        end else begin
            hcnt_q <= hcnt_d;
            hrun_q <= hrun_d;
            high_q <= high_d;
        end
    end

    assign high_cyc = high_q;
`else
    assign high_cyc = 28'd0;
`endif

endmodule

// File: tb/tb_clock_rate_detector.sv
// Self-checking bench for clock_rate_detector; expectations come from rise/fall cycle stamps.
module tb_clock_rate_detector;

    localparam int CLK_HZ = 1000;
    localparam int TOL    = 10;
    localparam int TMO    = 5000;
    localparam int LAT    = 2;  // edge index of a rise to the edge where it is acted upon

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        clk_in   = 1'b0;
    logic        clear    = 1'b0;
    logic [27:0] period_cyc, high_cyc;
    logic        period_valid, locked, timeout;
    logic [2:0]  rate_code;

    clock_rate_detector #(
        .CLK_HZ      (CLK_HZ),
        .TOL_CYC     (TOL),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .clk_in       (clk_in),
        .clear        (clear),
        .period_cyc   (period_cyc),
        .high_cyc     (high_cyc),
        .period_valid (period_valid),
        .rate_code    (rate_code),
        .locked       (locked),
        .timeout      (timeout)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int prev_r = 0, fall_r = 0, rise_r;
    bit armed = 0, fall_seen = 0, in_q = 0, in_los = 0;
    int prev_code = 0;
    int due = -1, los_due = -1, tclr_due = -1;
    int exp_p, exp_code, exp_lock, exp_high;

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int classify(input int p);
        if (absi(p - 4 * CLK_HZ) <= TOL) return 1;
        if (absi(p - 2 * CLK_HZ) <= TOL) return 2;
        if (absi(p - CLK_HZ) <= TOL)     return 3;
        if (absi(p - CLK_HZ / 2) <= TOL) return 4;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        armed = 0; fall_seen = 0; in_los = 0; prev_code = 0;
        due = -1; los_due = -1; tclr_due = -1;
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        cyc++;
        if (period_valid === 1'b1 || cyc == due) begin
            chk("period_valid", {31'd0, period_valid}, {31'd0, cyc == due});
            if (cyc == due) begin
                chk("period_cyc", period_cyc, exp_p);
                chk("rate_code", rate_code, exp_code);
                chk("locked", locked, exp_lock);
`ifdef CLOCK_RATE_DETECTOR_DUTY_EN
                chk("high_cyc", high_cyc, exp_high);
`else
                chk("high_cyc", high_cyc, 0);
`endif
                prev_code = exp_code;
                due = -1;
            end
        end
        if (cyc == los_due - 1) chk("timeout_early", timeout, 0);
        if (cyc == los_due) begin
            chk("timeout_set", timeout, 1);
            chk("los_code", rate_code, 7);
            chk("los_locked", locked, 0);
            armed = 0; in_los = 1; prev_code = 7; los_due = -1;
        end
        if (cyc == tclr_due - 1) chk("timeout_held", timeout, 1);
        if (cyc == tclr_due) begin
            chk("timeout_clr", timeout, 0);
            tclr_due = -1;
        end
    endtask

    task automatic set_in(input bit v);
        if (v && !in_q) begin
            rise_r = cyc + 1;
            if (armed) begin
                exp_p    = rise_r - prev_r;
                exp_code = classify(exp_p);
                exp_lock = (exp_code == prev_code && exp_code != 0) ? 1 : 0;
                exp_high = fall_seen ? fall_r - prev_r : exp_p;
                due      = rise_r + LAT;
            end
            if (in_los) begin
                tclr_due = rise_r + LAT;
                in_los = 0;
            end
            prev_r = rise_r; armed = 1; fall_seen = 0;
            los_due = rise_r + LAT + TMO;
        end else if (!v && in_q) begin
            fall_r = cyc + 1;
            fall_seen = 1;
        end
        in_q = v;
        clk_in = v;
    endtask

    task automatic run(input int period, input int high);
        for (int i = 0; i < period; i++) begin
            set_in(i < high);
            tick();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period"}, period_cyc, 0);
        chk({tag, "_high"}, high_cyc, 0);
        chk({tag, "_pv"}, period_valid, 0);
        chk({tag, "_code"}, rate_code, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        int p, h, n;
        model_reset();
        repeat (3) tick();
        chk_zero("reset");
        reset = 1'b0;
        repeat (5) tick();

        // 1000-cycle square wave, then the 500/2000 and tolerance sequence
        repeat (4) run(1000, 500);
        run(500, 250);
        run(2000, 1000);
        run(2000, 700);
        run(1011, 400);
        run(990, 500);
        run(1000, 500);

        // random periods near the nominals, including just outside tolerance
        for (int k = 0; k < 10; k++) begin
            n = $urandom_range(0, 2);
            p = ((n == 0) ? 500 : (n == 1) ? 1000 : 2000) + $urandom_range(0, 30) - 15;
            h = $urandom_range(2, p - 3);
            run(p, h);
        end

        // lock, then stop toggling until loss-of-signal, then recover
        run(1000, 500);
        run(1000, 500);
        run(1000, 500);
        for (int i = 0; i < TMO + 100; i++) begin
            set_in(1'b0);
            tick();
        end
        run(1000, 300);
        run(1000, 500);
        run(1000, 500);

        // asynchronous reset mid-period while locked
        run(1000, 500);
        for (int i = 0; i < 300; i++) tick();
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk_zero("async_reset");
        tick();
        tick();
        reset = 1'b0;
        run(1000, 500);
        run(1000, 500);
        run(1000, 500);
        run(1000, 500);

        // synchronous clear mid-period while locked
        for (int i = 0; i < 200; i++) tick();
        clear = 1'b1;
        model_reset();
        tick();
        chk_zero("clear");
        clear = 1'b0;
        tick();
        run(1000, 500);
        run(1000, 500);

        // duty measurement at the slowest rate
        run(4000, 1000);
        run(4000, 1000);
        run(1000, 500);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_rate_detector.md
Name: clock_rate_detector

Overview:
- Measures the period of a slow square-wave input (0.25/0.5/1/2 Hz class) in CLOCK_50 cycles.
- Classifies the measured period into a rate code and reports lock and loss-of-signal.
- Sits on the receiving side of the slow-clock generator outputs, for self-check and for board inputs of unknown rate.

Parameters:
- CLK_HZ, 50000000, reference clock frequency. Nominal periods are P2=CLK_HZ/2, P1=CLK_HZ, P05=2*CLK_HZ, P025=4*CLK_HZ cycles.
- TOL_CYC, 500000, allowed absolute deviation (cycles, inclusive) from a nominal period.
- TIMEOUT_CYC, 250000000, cycles without a rising edge before loss-of-signal. Must be > 4*CLK_HZ + TOL_CYC and < 2^28.

Ports:
- CLOCK_50  in  1  reference clock, all logic on its rising edge
- reset  in  1  asynchronous, active-high
- clk_in  in  1  slow input to measure, asynchronous to CLOCK_50
- clear  in  1  synchronous restart, active-high
- period_cyc  out  28  last measured period in CLOCK_50 cycles
- high_cyc  out  28  last measured high time (see Optional Feature)
- period_valid  out  1  one-cycle pulse when period_cyc/rate_code update
- rate_code  out  3  0=unclassified, 1=0.25Hz, 2=0.5Hz, 3=1Hz, 4=2Hz, 7=no signal
- locked  out  1  two consecutive equal nonzero classifications
- timeout  out  1  loss-of-signal flag

Behaviour:
- Reset, asynchronous. Clear, synchronous, same effect. All outputs 0, state IDLE, counter 0, synchronizer flops 0.
- Input path: 2-flop synchronizer, then a third flop for rising-edge detect. The edge pulse (edg) is asserted 3 CLOCK_50 edges after a clk_in rise that meets setup. Falling edge (fedg) is derived the same way.
- Counter cnt, 28 bits:
  - On edg: cleared to 1.
  - Otherwise: increments, saturating at TIMEOUT_CYC.
- States:
  - IDLE: cnt counts. On edg, go to MEASURE with no period_valid. If cnt reaches TIMEOUT_CYC, go to LOS.
  - MEASURE: on edg, period_cyc <= cnt, pulse period_valid, classify, stay. If cnt reaches TIMEOUT_CYC, go to LOS.
  - LOS: timeout=1, rate_code=7, locked=0, period_cyc held. On edg, go to MEASURE and clear timeout next cycle. No period_valid on that edge.
- Classification: code n is selected if |period - Pn| <= TOL_CYC; otherwise 0. Do the arithmetic with 29-bit signed intermediates, no wrap.
- rate_code and period_cyc are registered together with the period_valid pulse (same cycle).
- locked:
  - Set on a period_valid whose new code equals the previous code and is nonzero.
  - Cleared on any period_valid with a differing or zero code, on entering LOS, and on clear.
- Boundaries:
  - cnt reaches TIMEOUT_CYC in the same cycle as edg: edg wins, measurement taken.
  - clear in the same cycle as edg: clear wins.
  - Reset mid-period discards the partial count.
  - Glitches shorter than one CLOCK_50 cycle may be missed. No filtering.

Optional Feature:
- Macro: CLOCK_RATE_DETECTOR_DUTY_EN.
- Defined:
  - A second counter starts at edg and stops at fedg.
  - high_cyc <= that count, updated in the same cycle as period_valid.
  - If no fedg occurred in the period, high_cyc = period_cyc.
- Undefined: high_cyc is constant 0 and no second counter is synthesized.
- All other behaviour is identical in both builds.

Test Plan:
All scenarios use overrides CLK_HZ=1000, TOL_CYC=10, TIMEOUT_CYC=5000 (P2=500, P1=1000, P05=2000, P025=4000).
- Square wave, period 1000 cycles, 3 periods → first period_valid with period_cyc=1000, rate_code=3; locked=1 from second period_valid.
- Periods 500 then 2000 → rate_code 4 then 2, locked stays 0; then 2000 again → locked=1.
- Period 1011 (outside tolerance) → rate_code=0, locked=0; period 990 → rate_code=3.
- Stop toggling after lock → 5000 cycles after last edg: timeout=1, rate_code=7, locked=0; next edge clears timeout, no period_valid.
- Assert reset, then clear, mid-period and mid-lock → all outputs 0 immediately; next first edge produces no period_valid.
- With CLOCK_RATE_DETECTOR_DUTY_EN, period 4000 with high 1000 → period_cyc=4000, high_cyc=1000, rate_code=1. Without the macro → high_cyc=0.
